// File: rtl/dsi_packet_assembler_if.sv
// dsi_packet_assembler_if: packet request, payload-in and byte-out handshake bundle.
// Revision 1.0
`default_nettype none

interface dsi_packet_assembler_if;
  logic        pkt_start_i;
  logic        pkt_long_i;
  logic [1:0]  pkt_vc_i;
  logic [5:0]  pkt_type_i;
  logic [15:0] pkt_wc_i;
  logic [7:0]  d_i;
  logic        d_valid_i;
  logic        d_ready_o;
  logic [7:0]  q_o;
  logic        q_valid_o;
  logic        q_ready_i;
  logic        q_first_o;
  logic        q_last_o;
  logic        busy_o;
  logic        done_p_o;

  modport master (
    output pkt_start_i, pkt_long_i, pkt_vc_i, pkt_type_i, pkt_wc_i,
    output d_i, d_valid_i, q_ready_i,
    input  d_ready_o, q_o, q_valid_o, q_first_o, q_last_o, busy_o, done_p_o
  );

  modport slave (
    input  pkt_start_i, pkt_long_i, pkt_vc_i, pkt_type_i, pkt_wc_i,
    input  d_i, d_valid_i, q_ready_i,
    output d_ready_o, q_o, q_valid_o, q_first_o, q_last_o, busy_o, done_p_o
  );
endinterface

`default_nettype wire

// File: rtl/dsi_packet_assembler.sv
// dsi_packet_assembler: serialises one DSI packet (header + ECC, payload, CRC-16) per request.
// Revision 1.0
`default_nettype none

module dsi_packet_assembler (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  dsi_packet_assembler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRC     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic logic [7:0] ecc_calc(input logic [23:0] h);
    logic [5:0] p;
    p[0] = h[0]^h[1]^h[2]^h[4]^h[5]^h[7]^h[10]^h[11]^h[13]^h[16]^h[20]^h[21]^h[22]^h[23];
    p[1] = h[0]^h[1]^h[3]^h[4]^h[6]^h[8]^h[10]^h[12]^h[14]^h[17]^h[20]^h[21]^h[22]^h[23];
    p[2] = h[0]^h[2]^h[3]^h[5]^h[6]^h[9]^h[11]^h[12]^h[15]^h[18]^h[20]^h[21]^h[22];
    p[3] = h[1]^h[2]^h[3]^h[7]^h[8]^h[9]^h[13]^h[14]^h[15]^h[19]^h[20]^h[21]^h[23];
    p[4] = h[4]^h[5]^h[6]^h[7]^h[8]^h[9]^h[16]^h[17]^h[18]^h[19]^h[20]^h[22]^h[23];
    p[5] = h[10]^h[11]^h[12]^h[13]^h[14]^h[15]^h[16]^h[17]^h[18]^h[19]^h[21]^h[22]^h[23];
    return {2'b00, p};
  endfunction

  // Reflected CCITT polynomial, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'h8408 : 16'h0000);
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  type_q, type_d;
  logic [15:0] wc_q, wc_d;
  logic        long_q, long_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  q_q, q_d;
  logic        q_valid_q, q_valid_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        load_out;
  logic [7:0]  ecc;

  assign load_out = !q_valid_q || bus.q_ready_i;
  assign ecc      = ecc_calc({wc_q, vc_q, type_q});

  always_comb begin
    state_d   = state_q;
    vc_d      = vc_q;
    type_d    = type_q;
    wc_d      = wc_q;
    long_d    = long_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    first_d   = first_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.pkt_start_i) begin
          vc_d      = bus.pkt_vc_i;
          type_d    = bus.pkt_type_i;
          wc_d      = bus.pkt_wc_i;
          long_d    = bus.pkt_long_i;
          q_d       = {bus.pkt_vc_i, bus.pkt_type_i};
          q_valid_d = 1'b1;
          first_d   = 1'b1;
          last_d    = 1'b0;
          idx_d     = 2'd1;
          cnt_d     = 16'd0;
          crc_d     = 16'hFFFF;
          busy_d    = 1'b1;
          state_d   = S_HDR;
        end
      end

      S_HDR, S_PAYLOAD, S_CRC: begin
        if (load_out) begin
          // A held last byte being accepted closes the packet.
          if (q_valid_q && last_q) begin
            q_valid_d = 1'b0;
            first_d   = 1'b0;
            last_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            first_d = 1'b0;
            unique case (state_q)
              S_HDR: begin
                q_valid_d = 1'b1;
                idx_d     = idx_q + 2'd1;
                case (idx_q)
                  2'd1:    q_d = wc_q[7:0];
                  2'd2:    q_d = wc_q[15:8];
                  default: begin
                    q_d    = ecc;
                    last_d = !long_q;
                    if (long_q) begin
                      idx_d   = 2'd0;
                      cnt_d   = wc_q;
                      state_d = (wc_q == 16'd0) ? S_CRC : S_PAYLOAD;
                    end
                  end
                endcase
              end
              S_PAYLOAD: begin
                if (bus.d_valid_i) begin
                  q_d       = bus.d_i;
                  q_valid_d = 1'b1;
                  cnt_d     = cnt_q - 16'd1;
                  crc_d     = crc16_byte(crc_q, bus.d_i);
                  if (cnt_q == 16'd1) state_d = S_CRC;
                end else begin
                  q_valid_d = 1'b0;
                end
              end
              default: begin
                q_valid_d = 1'b1;
                if (idx_q == 2'd0) begin
                  q_d   = crc_q[7:0];
                  idx_d = 2'd1;
                end else begin
                  q_d    = crc_q[15:8];
                  last_d = 1'b1;
                end
              end
            endcase
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      vc_q      <= 2'd0;
      type_q    <= 6'd0;
      wc_q      <= 16'd0;
      long_q    <= 1'b0;
      idx_q     <= 2'd0;
      cnt_q     <= 16'd0;
      crc_q     <= 16'hFFFF;
      q_q       <= 8'd0;
      q_valid_q <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vc_q      <= vc_d;
      type_q    <= type_d;
      wc_q      <= wc_d;
      long_q    <= long_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.d_ready_o = (state_q == S_PAYLOAD) && load_out;
  assign bus.q_o       = q_q;
  assign bus.q_valid_o = q_valid_q;
  assign bus.q_first_o = first_q;
  assign bus.q_last_o  = last_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_p_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dsi_packet_assembler.sv
// tb_dsi_packet_assembler: directed vector table plus randomized packets against a reference model.
// Revision 1.0
`default_nettype none

module tb_dsi_packet_assembler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dsi_packet_assembler_if bus ();

  dsi_packet_assembler dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef bit [7:0] bq_t [$];

  typedef struct {
    bit         lng;
    bit [1:0]   vc;
    bit [5:0]   dt;
    bit [15:0]  wc;
    bit         bp;
    bit         poke;
    int         n;
    bit [119:0] exp;
  } vec_t;

  // Syndrome column of each header bit in the DSI Hamming code.
  localparam bit [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  int  checks = 0;
  int  errors = 0;
  bq_t pay;
  bq_t got;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit [7:0] ecc_ref(bit [23:0] h);
    bit [5:0] e = 6'd0;
    for (int j = 0; j < 24; j++) if (h[j]) e ^= ECC_COL[j];
    return {2'b00, e};
  endfunction

  // Byte-at-a-time CCITT update (reflected), equivalent to the bitwise definition.
  function automatic bit [15:0] crc_ref(bq_t p);
    bit [15:0] c = 16'hFFFF;
    bit [7:0]  x;
    foreach (p[i]) begin
      x = p[i] ^ c[7:0];
      x = x ^ (x << 4);
      c = {x, c[15:8]} ^ {8'h00, x >> 4} ^ ({8'h00, x} << 3);
    end
    return c;
  endfunction

  function automatic void build_exp(bit lng, bit [1:0] vc, bit [5:0] dt, bit [15:0] wc,
                                    bq_t p, output bq_t e);
    bit [7:0]  di = {vc, dt};
    bit [15:0] c;
    e = {};
    e.push_back(di);
    e.push_back(wc[7:0]);
    e.push_back(wc[15:8]);
    e.push_back(ecc_ref({wc, di}));
    if (lng) begin
      foreach (p[i]) e.push_back(p[i]);
      c = crc_ref(p);
      e.push_back(c[7:0]);
      e.push_back(c[15:8]);
    end
  endfunction

  task automatic chk_all_zero(string tag);
    chk({tag, "_q"},       bus.q_o,       0);
    chk({tag, "_q_valid"}, bus.q_valid_o, 0);
    chk({tag, "_first"},   bus.q_first_o, 0);
    chk({tag, "_last"},    bus.q_last_o,  0);
    chk({tag, "_d_ready"}, bus.d_ready_o, 0);
    chk({tag, "_busy"},    bus.busy_o,    0);
    chk({tag, "_done"},    bus.done_p_o,  0);
  endtask

  task automatic run_pkt(input bit lng, input bit [1:0] vc, input bit [5:0] dt,
                         input bit [15:0] wc, input bit bp, input bit poke,
                         input int abort_at, output int last_cyc);
    bq_t        exp;
    int         cyc = 0;
    int         pi = 0;
    bit         fin = 0, seen_last = 0, stalled = 0, any_dr = 0, aborted = 0;
    logic [9:0] hold = '0;
    build_exp(lng, vc, dt, wc, pay, exp);
    got.delete();
    last_cyc = -1;

    @(negedge clk);
    bus.pkt_start_i = 1'b1;
    bus.pkt_long_i  = lng;
    bus.pkt_vc_i    = vc;
    bus.pkt_type_i  = dt;
    bus.pkt_wc_i    = wc;
    bus.q_ready_i   = 1'b1;
    bus.d_valid_i   = 1'b0;
    #1;
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_done", bus.done_p_o, 0);

    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.pkt_start_i = poke ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (poke) begin
        bus.pkt_long_i = 1'($urandom_range(0, 1));
        bus.pkt_vc_i   = 2'($urandom);
        bus.pkt_type_i = 6'($urandom);
        bus.pkt_wc_i   = 16'($urandom);
      end
      bus.q_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pi < pay.size()) begin
        bus.d_valid_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.d_i       = pay[pi];
      end else begin
        bus.d_valid_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.d_i       = 8'($urandom);
      end
      #1;
      if (stalled) chk("stall_hold", {bus.q_o, bus.q_first_o, bus.q_last_o}, hold);
      stalled = bus.q_valid_o && !bus.q_ready_i;
      hold    = {bus.q_o, bus.q_first_o, bus.q_last_o};
      if (seen_last) begin
        chk("done_pulse", bus.done_p_o, 1);
        chk("busy_in_done", bus.busy_o, 1);
        fin = 1;
      end else begin
        chk("done_low", bus.done_p_o, 0);
        if (bus.d_ready_o) any_dr = 1;
        if (bus.d_valid_i && bus.d_ready_o) pi++;
        if (bus.q_valid_o && bus.q_ready_i) begin
          chk("first_flag", bus.q_first_o, got.size() == 0);
          got.push_back(bus.q_o);
          chk("last_flag", bus.q_last_o, got.size() == exp.size());
          if (bus.q_last_o) begin
            seen_last = 1;
            last_cyc  = cyc;
          end
        end
        if (abort_at > 0 && pi == abort_at) begin
          fin     = 1;
          aborted = 1;
        end
      end
      if (!fin && cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL timeout: packet not finished after %0d cycles, %0d bytes seen", cyc, got.size());
        fin = 1;
      end
    end
    bus.pkt_start_i = 1'b0;
    bus.d_valid_i   = 1'b0;

    if (!aborted) begin
      chk("len", got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
        chk($sformatf("byte%0d", i), got[i], exp[i]);
      chk("payload_taken", pi, lng ? int'(wc) : 0);
      if (lng && wc == 16'd0) chk("no_d_ready", any_dr, 0);
      if (!bp) chk("latency", last_cyc, exp.size());
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int lc;
    pay.delete();
    if (v.lng) for (int i = 0; i < int'(v.wc); i++) pay.push_back(8'h31 + i[7:0]);
    run_pkt(v.lng, v.vc, v.dt, v.wc, v.bp, v.poke, 0, lc);
    chk("tbl_len", got.size(), v.n);
    for (int i = 0; i < v.n && i < got.size(); i++)
      chk($sformatf("tbl_byte%0d", i), got[i], v.exp[8*(v.n-1-i) +: 8]);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   lc;
    bit   lng;
    bit [15:0] wc;

    tbl[0] = '{1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, 1'b0, 4, 120'h05110036};
    tbl[1] = '{1'b1, 2'd0, 6'h39, 16'd9, 1'b0, 1'b0, 15,
               120'h39090030313233343536373839916F};
    tbl[2] = '{1'b1, 2'd0, 6'h39, 16'd0, 1'b0, 1'b0, 6, 120'h3900000FFFFF};
    tbl[3] = '{1'b1, 2'd0, 6'h39, 16'd9, 1'b1, 1'b0, 15,
               120'h39090030313233343536373839916F};
    tbl[4] = '{1'b1, 2'd0, 6'h39, 16'd9, 1'b0, 1'b1, 15,
               120'h39090030313233343536373839916F};
    tbl[5] = '{1'b0, 2'd0, 6'h05, 16'h0011, 1'b1, 1'b0, 4, 120'h05110036};

    bus.pkt_start_i = 1'b0;
    bus.pkt_long_i  = 1'b0;
    bus.pkt_vc_i    = 2'd0;
    bus.pkt_type_i  = 6'd0;
    bus.pkt_wc_i    = 16'd0;
    bus.d_i         = 8'd0;
    bus.d_valid_i   = 1'b0;
    bus.q_ready_i   = 1'b1;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) apply_vec(tbl[k]);

    // Abandon a long packet after its 5th payload byte.
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
    run_pkt(1'b1, 2'd1, 6'h2A, 16'd20, 1'b0, 1'b0, 5, lc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(tbl[0]);
    apply_vec(tbl[1]);

    for (int r = 0; r < 30; r++) begin
      lng = 1'($urandom_range(0, 1));
      wc  = lng ? 16'($urandom_range(0, 24)) : 16'($urandom);
      pay.delete();
      if (lng) for (int i = 0; i < int'(wc); i++) pay.push_back(8'($urandom));
      run_pkt(lng, 2'($urandom), 6'($urandom), wc, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, lc);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
